// File: rtl/pc_pkg.sv
// Shared types for the PC with return-address stack: action decode enum and
// the count-width helper used by the stack and its users.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_RESET,
    PC_SWAP,
    PC_RET,
    PC_CALL,
    PC_LOAD,
    PC_INC,
    PC_HOLD
  } pc_action_e;

  // Count must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses with push, pop and replace-top.
// Macro PC_CALL_STACK_CIRCULAR_EN: a push on full overwrites the oldest entry.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             replace_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    ptr_inc, ptr_dec, wr_idx;
  logic             wr_en, can_push;

  // The top pointer wraps, so a circular push on full lands on the oldest slot.
  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PW'(1);

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign top_o   = mem_q[ptr_q];

`ifdef PC_CALL_STACK_CIRCULAR_EN
  assign can_push = 1'b1;
`else
  assign can_push = !full_o;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (replace_i && !empty_o) begin
      wr_en = 1'b1;
    end else if (push_i && can_push) begin
      ptr_d  = ptr_inc;
      wr_idx = ptr_inc;
      wr_en  = 1'b1;
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
      ptr_q <= PTR_LAST;
      // NOTE: entries are cleared on reset because stale return addresses must not survive it.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      if (wr_en) mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with reset/load/inc/hold plus call/return via a return-address stack.
// Macro PC_CALL_STACK_CIRCULAR_EN selects overwrite-oldest instead of overflow error.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full,
  output logic             err
);

  pc_action_e       action;
  logic [WIDTH-1:0] out_q, out_d, out_plus1, top;
  logic             err_q, err_d;
  logic             st_clr, st_push, st_pop, st_replace;

  assign out_plus1 = out_q + WIDTH'(1);

  always_comb begin
    if (reset)            action = PC_RESET;
    else if (call && ret) action = PC_SWAP;
    else if (ret)         action = PC_RET;
    else if (call)        action = PC_CALL;
    else if (load)        action = PC_LOAD;
    else if (inc)         action = PC_INC;
    else                  action = PC_HOLD;
  end

  always_comb begin
    out_d      = out_q;
    err_d      = err_q;
    st_clr     = 1'b0;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_replace = 1'b0;
    unique case (action)
      PC_RESET: begin
        out_d  = RESET_VEC;
        err_d  = 1'b0;
        st_clr = 1'b1;
      end
      PC_SWAP: begin
        // Tail-swap degrades to a plain call when there is no top to replace.
        out_d      = in;
        st_push    = empty;
        st_replace = !empty;
      end
      PC_RET: begin
        if (empty) begin
          out_d = out_plus1;
          err_d = 1'b1;
        end else begin
          out_d  = top;
          st_pop = 1'b1;
        end
      end
      PC_CALL: begin
        out_d   = in;
        st_push = 1'b1;
`ifndef PC_CALL_STACK_CIRCULAR_EN
        if (full) err_d = 1'b1;
`endif
      end
      PC_LOAD: out_d = in;
      PC_INC:  out_d = out_plus1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
    err_q <= err_d;
  end

  pc_ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk      (clk),
    .clr_i    (st_clr),
    .push_i   (st_push),
    .pop_i    (st_pop),
    .replace_i(st_replace),
    .data_i   (out_plus1),
    .top_o    (top),
    .empty_o  (empty),
    .full_o   (full)
  );

  assign out = out_q;
  assign err = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: a default-size instance and a DEPTH=2 instance,
// directed vectors push expected state; a monitor compares after each rising edge.
module tb_pc_call_stack;

  localparam int W = 16;

  // Operation bits {reset, call, ret, load, inc}
  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] RST = 5'b10000;
  localparam logic [4:0] CAL = 5'b01000;
  localparam logic [4:0] RET = 5'b00100;
  localparam logic [4:0] SWP = 5'b01100;
  localparam logic [4:0] LD  = 5'b00010;
  localparam logic [4:0] INC = 5'b00001;

  typedef struct {
    int          unit;
    string       name;
    logic [W-1:0] out;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]   op_a = RST, op_b = RST;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] out_a, out_b;
  logic         empty_a, full_a, err_a, empty_b, full_b, err_b;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  pc_call_stack dut_a (
    .clk(clk), .reset(op_a[4]), .call(op_a[3]), .ret(op_a[2]), .load(op_a[1]), .inc(op_a[0]),
    .in(in_a), .out(out_a), .empty(empty_a), .full(full_a), .err(err_a)
  );

  pc_call_stack #(.WIDTH(W), .DEPTH(2)) dut_b (
    .clk(clk), .reset(op_b[4]), .call(op_b[3]), .ret(op_b[2]), .load(op_b[1]), .inc(op_b[0]),
    .in(in_b), .out(out_b), .empty(empty_b), .full(full_b), .err(err_b)
  );

  task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got out=%0d empty=%0b full=%0b err=%0b, want out=%0d empty=%0b full=%0b err=%0b",
               name, act[W+2:3], act[2], act[1], act[0], req[W+2:3], req[2], req[1], req[0]);
    end
  endtask

  // Drive one cycle on the chosen unit (the other holds) and record its expected result.
  task automatic step(input int unit, input logic [4:0] op, input logic [W-1:0] din,
                      input logic [W-1:0] e_out, input logic e_empty, input logic e_full,
                      input logic e_err, input string name);
    exp_t e;
    @(negedge clk);
    op_a = NOP;
    op_b = NOP;
    if (unit == 0) begin op_a = op; in_a = din; end
    else           begin op_b = op; in_b = din; end
    e.unit = unit; e.name = name; e.out = e_out;
    e.empty = e_empty; e.full = e_full; e.err = e_err;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents new state every edge; compare against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.unit == 0) check(e.name, {out_a, empty_a, full_a, err_a}, {e.out, e.empty, e.full, e.err});
        else             check(e.name, {out_b, empty_b, full_b, err_b}, {e.out, e.empty, e.full, e.err});
      end
    end
  end

  initial begin
    // Default instance: reset, increments, call/ret, underflow.
    step(0, RST, 0, 0, 1, 0, 0, "reset_a");
    step(0, INC, 0, 1, 1, 0, 0, "inc1");
    step(0, INC, 0, 2, 1, 0, 0, "inc2");
    step(0, INC, 0, 3, 1, 0, 0, "inc3");
    step(0, INC, 0, 4, 1, 0, 0, "inc4");
    step(0, INC, 0, 5, 1, 0, 0, "inc5");
    step(0, CAL, 100, 100, 0, 0, 0, "call100");
    step(0, INC, 0, 101, 0, 0, 0, "inc_in_sub");
    step(0, RET, 0, 6, 1, 0, 0, "ret_to_6");
    step(0, INC, 0, 7, 1, 0, 0, "inc7");
    step(0, RET, 0, 8, 1, 0, 1, "underflow");
    step(0, INC, 0, 9, 1, 0, 1, "err_sticky_inc");
    step(0, NOP, 0, 9, 1, 0, 1, "err_sticky_hold");
    step(0, RST, 0, 0, 1, 0, 0, "reset_clears_err");
    // Return-address wrap.
    step(0, LD, 16'hFFFF, 16'hFFFF, 1, 0, 0, "load_ffff");
    step(0, CAL, 3, 3, 0, 0, 0, "call_wrap");
    step(0, INC, 0, 4, 0, 0, 0, "inc_after_wrap");
    step(0, RET, 0, 0, 1, 0, 0, "ret_wrapped_0");
    // Tail-swap: top 50 replaced with 41, count unchanged.
    step(0, LD, 49, 49, 1, 0, 0, "load49");
    step(0, CAL, 7, 7, 0, 0, 0, "call_push50");
    step(0, LD, 40, 40, 0, 0, 0, "load40");
    step(0, SWP, 200, 200, 0, 0, 0, "swap200");
    step(0, RET, 0, 41, 1, 0, 0, "ret_swapped_41");
    // Swap followed by reset discards stack.
    step(0, LD, 49, 49, 1, 0, 0, "load49b");
    step(0, CAL, 7, 7, 0, 0, 0, "call_push50b");
    step(0, LD, 40, 40, 0, 0, 0, "load40b");
    step(0, SWP, 200, 200, 0, 0, 0, "swap200b");
    step(0, RST, 0, 0, 1, 0, 0, "reset_mid_seq");
    step(0, RET, 0, 1, 1, 0, 1, "ret_after_reset_empty");
    step(0, RST, 0, 0, 1, 0, 0, "reset_again");
    // Swap on empty acts as call; load beats inc.
    step(0, SWP, 300, 300, 0, 0, 0, "swap_on_empty");
    step(0, RET, 0, 1, 1, 0, 0, "ret_from_swap_empty");
    step(0, LD | INC, 500, 500, 1, 0, 0, "load_over_inc");
    step(0, RST | CAL, 9, 0, 1, 0, 0, "reset_over_call");

    // DEPTH=2 instance: overflow behaviour.
    step(1, RST, 0, 0, 1, 0, 0, "reset_b");
    step(1, LD, 10, 10, 1, 0, 0, "b_load10");
    step(1, CAL, 20, 20, 0, 0, 0, "b_call20");
    step(1, CAL, 30, 30, 0, 1, 0, "b_call30_full");
`ifdef PC_CALL_STACK_CIRCULAR_EN
    step(1, CAL, 40, 40, 0, 1, 0, "b_call40_circ");
    step(1, RET, 0, 31, 0, 0, 0, "b_ret31");
    step(1, RET, 0, 21, 1, 0, 0, "b_ret21");
`else
    step(1, CAL, 40, 40, 0, 1, 1, "b_call40_ovf");
    step(1, RET, 0, 21, 0, 0, 1, "b_ret21");
    step(1, RET, 0, 11, 1, 0, 1, "b_ret11");
`endif

    // Bounded drain of the scoreboard.
    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter with a hardware return-address stack; successor to the 16-bit PC in the CPU datapath. It keeps the PC semantics (reset, load, increment, hold) and adds call/return: a call jumps to `in` and pushes the return address `out+1`, and a return pops it back into the PC. It sits between the control unit's jump/call decode and instruction-memory addressing.

## Interface
- `WIDTH`, 16: PC and return-address width in bits (≥2).
- `DEPTH`, 8: return-stack entries (≥1).
- `RESET_VEC`, 0: value loaded into `out` on reset.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; one clock, with synchronous active-high reset, as already decided.
- `load`  in  1: jump, `out <= in`.
- `inc`  in  1: `out <= out + 1`.
- `call`  in  1: jump to `in` and push `out + 1`.
- `ret`  in  1: pop the top entry into `out`.
- `in`  in  WIDTH: jump/call target.
- `out`  out  WIDTH: current PC (registered).
- `empty`  out  1: stack count == 0.
- `full`  out  1: stack count == DEPTH.
- `err`  out  1: sticky flag, set on overflow or underflow.

## Operation
Exactly one action per rising edge, chosen by priority: reset > call&ret > ret > call > load > inc > hold.
- **reset:** `out <= RESET_VEC`, count 0, all entries 0, `err` 0.
- **call&ret (tail-swap):** `out <= in`; top entry replaced with `out+1`; count unchanged. If the stack is empty, behaves as a plain call.
- **ret, count>0:** `out <= top`; count decrements.
- **ret, empty:** underflow. `out <= out + 1`, so execution falls through; `err <= 1`; count stays 0.
- **call, not full:** `out <= in`; push `out+1`; count increments.
- **call, full:** overflow. Behaviour is set by the macro under Configuration; `out <= in` in both builds.
- **load:** `out <= in`. **inc:** `out <= out + 1`. Neither touches the stack.
- **Arithmetic:** `out + 1` is modulo 2^WIDTH (all-ones wraps to 0). The pushed return address wraps the same way.
- Count is `$clog2(DEPTH+1)` bits and ranges 0..DEPTH.

## Timing
- All state changes on the rising edge of `clk`, with 1-cycle latency from inputs to `out`.
- `out`, `err` and the count are registers. `empty` and `full` are decoded combinationally from the registered count.
- No combinational path from any input to `out`.
- A reset asserted mid-sequence (e.g. between a call and its ret) discards all stack contents that cycle.
- Back-to-back call/ret on every cycle is supported, with no bubbles.
- After reset: `out`=RESET_VEC, `empty`=1, `full`=0, `err`=0.

## Configuration
Macro `PC_CALL_STACK_CIRCULAR_EN`:
- **Defined:** call on full overwrites the oldest entry (circular buffer). The stack stays full, `err` is not set, and later rets return the DEPTH most recent addresses.
- **Undefined:** call on full drops the push, sets `err`, and keeps the stack unchanged.

## Structure
- Package `pc_pkg`:
  - action enum `PC_RESET`, `PC_SWAP`, `PC_RET`, `PC_CALL`, `PC_LOAD`, `PC_INC`, `PC_HOLD`;
  - count-width function.
- Sub-module `pc_ret_stack`: LIFO storage with push, pop and replace-top ports, count, full/empty, and circular mode handled via the macro.
- The top level holds the priority decode, the `out` register and the `err` register.

## Test plan
- Reset, then `inc` for 3 cycles → `out` = 0,1,2,3; `empty`=1.
- At `out`=5, `call` with `in`=100 → `out`=100 next cycle; then `inc`; then `ret` → `out`=6, `empty`=1.
- `ret` on an empty stack at `out`=7 → `out`=8 and `err`=1, held until reset.
- WIDTH=16 at `out`=16'hFFFF, `call` with `in`=3 → pushed 0; a later `ret` gives `out`=0.
- DEPTH=2, three nested calls from 10, 20, 30:
  - Undefined build: `full`=1, `err`=1, rets yield 21 then 11.
  - Circular build: `err`=0, rets yield 31 then 21.
- `call`+`ret` together with top=50 and `in`=200 at `out`=40 → `out`=200, top=41, count unchanged. A `reset` asserted on the next cycle → `out`=RESET_VEC, `empty`=1.
